led_status_ctrl: RTL

Parametrised status-LED controller that drives N on-board LEDs from per-channel mode registers. It replaces hard-wired heartbeat and lock indicators with runtime-selectable patterns: off, on, slow and fast blink, N-flash burst, and event pulse-stretch. Pattern timing derives from an internal prescaled tick. The block sits at the top level, between system status sources (PLL lock, datapath events, debug FSMs) and the board LED pins.

---
 rtl/led_status_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/led_status_ctrl.sv
// Status-LED controller: per-channel OFF/ON/blink/burst/pulse patterns on a shared 8 Hz tick.
// Optional build macro LED_PWM_DIM_EN adds a 4-bit `dim` input and PWM brightness gating.
module led_status_ctrl #(
  parameter int N_LED         = 6,
  parameter int CLK_HZ        = 27_000_000,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STRETCH_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_idx,
  input  logic [2:0]       cfg_mode,
  input  logic [3:0]       cfg_count,
`ifdef LED_PWM_DIM_EN
  input  logic [3:0]       dim,
`endif
  input  logic [N_LED-1:0] evt,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int TICK_DIV = CLK_HZ / 8;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [3:0] STRETCH_LD = 4'(STRETCH_TICKS);

  localparam logic [2:0] M_ON    = 3'd1;
  localparam logic [2:0] M_SLOW  = 3'd2;
  localparam logic [2:0] M_FAST  = 3'd3;
  localparam logic [2:0] M_BURST = 3'd4;
  localparam logic [2:0] M_PULSE = 3'd5;

  typedef enum logic [1:0] {
    B_ON  = 2'd0,
    B_OFF = 2'd1,
    B_GAP = 2'd2
  } burst_e;

  function automatic logic pattern_lit(input logic [2:0] m, input logic [2:0] ph,
                                       input logic burst_on, input logic pulse_on);
    logic r;
    r = 1'b0;
    case (m)
      M_ON:    r = 1'b1;
      M_SLOW:  r = ph[2];
      M_FAST:  r = ph[0];
      M_BURST: r = burst_on;
      M_PULSE: r = pulse_on;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       phase_q, phase_d;
  logic             pwm_on;

  always_comb begin
    tick    = (pre_q == PRE_MAX);
    pre_d   = tick ? '0 : pre_q + 1'b1;
    phase_d = tick ? phase_q + 3'd1 : phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q   <= '0;
      phase_q <= '0;
    end else begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
    end
  end

`ifdef LED_PWM_DIM_EN
  logic [3:0] pwm_q, pwm_d;

  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    pwm_on = (pwm_q <= dim);
  end

  always_ff @(posedge clk) begin
    if (rst) pwm_q <= '0;
    else     pwm_q <= pwm_d;
  end
`else
  assign pwm_on = 1'b1;
`endif

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    logic [2:0] mode_q, mode_d;
    logic [3:0] count_q, count_d;
    burst_e     st_q, st_d;
    logic [3:0] flash_q, flash_d;
    logic [1:0] gap_q, gap_d;
    logic [3:0] str_q, str_d;
    logic       led_q, led_d;
    logic       wr_hit, lit;

    // Comparing against the channel's own index also rejects idx >= N_LED.
    assign wr_hit = cfg_we && (cfg_idx == 4'(g));

    always_comb begin
      mode_d  = mode_q;
      count_d = count_q;
      st_d    = st_q;
      flash_d = flash_q;
      gap_d   = gap_q;
      str_d   = str_q;
      if (wr_hit) begin
        mode_d  = cfg_mode;
        count_d = cfg_count;
        st_d    = B_ON;
        flash_d = '0;
        gap_d   = '0;
        str_d   = '0;
      end else begin
        if (tick) begin
          case (st_q)
            B_ON: begin
              if (count_q == 4'd0) begin
                st_d  = B_GAP;
                gap_d = '0;
              end else begin
                st_d    = B_OFF;
                flash_d = flash_q + 4'd1;
              end
            end
            B_OFF: begin
              if (flash_q < count_q) begin
                st_d = B_ON;
              end else begin
                st_d  = B_GAP;
                gap_d = '0;
              end
            end
            default: begin
              if (gap_q == 2'd3) begin
                gap_d = '0;
                if (count_q != 4'd0) begin
                  st_d    = B_ON;
                  flash_d = '0;
                end
              end else begin
                gap_d = gap_q + 2'd1;
              end
            end
          endcase
        end
        // A load in the same cycle as a tick takes precedence over the decrement.
        if (evt[g] && (mode_q == M_PULSE)) str_d = STRETCH_LD;
        else if (tick && (str_q != 4'd0))  str_d = str_q - 4'd1;
      end
    end

    always_comb begin
      lit   = pattern_lit(mode_q, phase_q, (st_q == B_ON) && (count_q != 4'd0), str_q != 4'd0);
      led_d = (lit & pwm_on) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q  <= '0;
        count_q <= '0;
        st_q    <= B_ON;
        flash_q <= '0;
        gap_q   <= '0;
        str_q   <= '0;
        led_q   <= ACTIVE_LOW;
      end else begin
        mode_q  <= mode_d;
        count_q <= count_d;
        st_q    <= st_d;
        flash_q <= flash_d;
        gap_q   <= gap_d;
        str_q   <= str_d;
        led_q   <= led_d;
      end
    end

    assign led[g] = led_q;
  end

endmodule
